digit_led_capture: RTL and testbench



---
 rtl/digit_led_capture.sv | 159 +++++++++++++++
 tb/tb_digit_led_capture.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/digit_led_capture.sv
// digit_led_capture: passively decodes a multiplexed 4-digit active-low 7-segment bus
// back into hex nibbles and reassembles complete 16-bit frames.
`default_nettype none

module digit_led_capture #(
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 65535,
    parameter int CNT_W      = 16
) (
    input  logic        clk_fresh,
    input  logic        rst_n,
    input  logic [6:0]  smg_7_in,
    input  logic [3:0]  smg_4_in,
    output logic [15:0] O_data,
    output logic        O_valid,
    output logic        O_err,
    output logic        O_stale
);

    localparam int SC_W = $clog2(STABLE_CNT + 1);
    localparam logic [SC_W-1:0]  STABLE_MAX = SC_W'(STABLE_CNT);
    localparam logic [SC_W-1:0]  STABLE_ACC = SC_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] TMO_MAX    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t            state;
    logic [10:0]       sync1;
    logic [10:0]       sync2;
    logic [10:0]       prev;
    logic [SC_W-1:0]   stab_cnt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [15:0]       shadow;
    logic [3:0]        seen;
    logic              err_flag;

    logic              accept;
    logic              dig_valid;
    logic              anode_blank;
    logic [1:0]        dig_idx;
    logic [3:0]        nib;
    logic              seg_bad;
    logic [15:0]       merged;
    logic [3:0]        new_seen;
    logic              tmo_fire;

    // Returns {invalid, nibble}; unknown patterns decode to nibble 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: seg_decode = 5'h00;
            7'b1001111: seg_decode = 5'h01;
            7'b0010010: seg_decode = 5'h02;
            7'b0000110: seg_decode = 5'h03;
            7'b1001100: seg_decode = 5'h04;
            7'b0100100: seg_decode = 5'h05;
            7'b0100000: seg_decode = 5'h06;
            7'b0001111: seg_decode = 5'h07;
            7'b0000000: seg_decode = 5'h08;
            7'b0000100: seg_decode = 5'h09;
            7'b0001000: seg_decode = 5'h0A;
            7'b1100000: seg_decode = 5'h0B;
            7'b0110001: seg_decode = 5'h0C;
            7'b1000010: seg_decode = 5'h0D;
            7'b0110000: seg_decode = 5'h0E;
            7'b0111000: seg_decode = 5'h0F;
            default:    seg_decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        accept      = (sync2 == prev) && (stab_cnt == STABLE_ACC);
        dig_valid   = 1'b0;
        anode_blank = 1'b0;
        dig_idx     = 2'd0;
        case (sync2[10:7])
            4'b0111: begin dig_valid = 1'b1; dig_idx = 2'd3; end
            4'b1011: begin dig_valid = 1'b1; dig_idx = 2'd2; end
            4'b1101: begin dig_valid = 1'b1; dig_idx = 2'd1; end
            4'b1110: begin dig_valid = 1'b1; dig_idx = 2'd0; end
            4'b1111: anode_blank = 1'b1;
            default: ;
        endcase
        {seg_bad, nib} = seg_decode(sync2[6:0]);
        merged                        = shadow;
        merged[{dig_idx, 2'b00} +: 4] = nib;
        new_seen = ((state == IDLE) ? 4'b0000 : seen) | (4'b0001 << dig_idx);
        // An accept in the same cycle wins over the timeout.
        tmo_fire = !accept && (tmo_cnt == TMO_LAST);
    end

    always_ff @(posedge clk_fresh or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '1;
            sync2    <= '1;
            prev     <= '1;
            stab_cnt <= '0;
            tmo_cnt  <= '0;
            shadow   <= '0;
            seen     <= '0;
            err_flag <= 1'b0;
            state    <= IDLE;
            O_data   <= '0;
            O_valid  <= 1'b0;
            O_err    <= 1'b0;
            O_stale  <= 1'b1;
        end else begin
            sync1 <= {smg_4_in, smg_7_in};
            sync2 <= sync1;
            prev  <= sync2;

            if (sync2 == prev) begin
                if (stab_cnt != STABLE_MAX)
                    stab_cnt <= stab_cnt + 1'b1;
            end else begin
                stab_cnt <= '0;
            end

            if (accept)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 1'b1;

            O_valid <= 1'b0;

            if (accept) begin
                if (dig_valid) begin
                    if (new_seen == 4'b1111) begin
                        O_data   <= merged;
                        O_valid  <= 1'b1;
                        O_err    <= err_flag | seg_bad;
                        O_stale  <= 1'b0;
                        seen     <= '0;
                        err_flag <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        shadow   <= merged;
                        seen     <= new_seen;
                        err_flag <= err_flag | seg_bad;
                        state    <= COLLECT;
                    end
                end else if (!anode_blank) begin
                    err_flag <= 1'b1;
                end
            end else if (tmo_fire) begin
                seen     <= '0;
                err_flag <= 1'b0;
                O_stale  <= 1'b1;
                state    <= IDLE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_digit_led_capture.sv
// tb_digit_led_capture: scoreboard bench for digit_led_capture (TIMEOUT shortened to 100).
`default_nettype none

module tb_digit_led_capture;

    localparam int TIMEOUT   = 100;
    localparam int DIGIT_CYC = 16;
    localparam int LATENCY   = 7;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk_fresh = 1'b0;
    logic        rst_n;
    logic [6:0]  smg_7_in;
    logic [3:0]  smg_4_in;
    logic [15:0] O_data;
    logic        O_valid;
    logic        O_err;
    logic        O_stale;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk_fresh = ~clk_fresh;
    always @(posedge clk_fresh) cyc <= cyc + 1;

    digit_led_capture #(
        .STABLE_CNT (4),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (16)
    ) dut (
        .clk_fresh (clk_fresh),
        .rst_n     (rst_n),
        .smg_7_in  (smg_7_in),
        .smg_4_in  (smg_4_in),
        .O_data    (O_data),
        .O_valid   (O_valid),
        .O_err     (O_err),
        .O_stale   (O_stale)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'b0000001;  4'h1: seg_of = 7'b1001111;
            4'h2: seg_of = 7'b0010010;  4'h3: seg_of = 7'b0000110;
            4'h4: seg_of = 7'b1001100;  4'h5: seg_of = 7'b0100100;
            4'h6: seg_of = 7'b0100000;  4'h7: seg_of = 7'b0001111;
            4'h8: seg_of = 7'b0000000;  4'h9: seg_of = 7'b0000100;
            4'hA: seg_of = 7'b0001000;  4'hB: seg_of = 7'b1100000;
            4'hC: seg_of = 7'b0110001;  4'hD: seg_of = 7'b1000010;
            4'hE: seg_of = 7'b0110000;  default: seg_of = 7'b0111000;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        an_of = ~(one << idx);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_fresh);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        smg_4_in = an;
        smg_7_in = seg;
        tick(n);
    endtask

    // Drives the frame-completing digit and records when its pulse is due.
    task automatic drive_last(input logic [3:0] an, input logic [6:0] seg,
                              input logic [15:0] data, input logic err);
        exp_t e;
        smg_4_in = an;
        smg_7_in = seg;
        e.data = data;
        e.err  = err;
        e.cyc  = cyc;
        sb.push_back(e);
        tick(DIGIT_CYC);
    endtask

    task automatic sweep(input logic [15:0] v, input logic err);
        for (int i = 3; i >= 1; i--)
            drive(an_of(i), seg_of(v[i*4 +: 4]), DIGIT_CYC);
        drive_last(an_of(0), seg_of(v[3:0]), v, err);
    endtask

    always @(negedge clk_fresh) begin
        if (rst_n === 1'b1 && O_valid === 1'b1) begin
            check_eq("valid_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_eq("frame_data", O_data, mon_e.data);
                check_eq("frame_err", O_err, mon_e.err);
                check_eq("frame_stale", O_stale, 0);
                check_eq("frame_latency", cyc - mon_e.cyc, LATENCY);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        smg_4_in = 4'b1111;
        smg_7_in = 7'b1111111;
        tick(3);
        check_eq("rst_data", O_data, 0);
        check_eq("rst_valid", O_valid, 0);
        check_eq("rst_err", O_err, 0);
        check_eq("rst_stale", O_stale, 1);
        rst_n = 1'b1;
        tick(40);
        check_eq("idle_data", O_data, 0);
        check_eq("idle_valid", O_valid, 0);
        check_eq("idle_err", O_err, 0);
        check_eq("idle_stale", O_stale, 1);

        sweep(16'h1A2F, 1'b0);
        sweep(16'h1A2F, 1'b0);

        // Short all-segments glitch inside digit 2 must be filtered.
        drive(an_of(3), seg_of(4'h1), DIGIT_CYC);
        drive(an_of(2), seg_of(4'hA), 4);
        drive(an_of(2), 7'b0000000, 3);
        drive(an_of(2), seg_of(4'hA), 9);
        drive(an_of(1), seg_of(4'h2), DIGIT_CYC);
        drive_last(an_of(0), seg_of(4'hF), 16'h1A2F, 1'b0);

        drive(an_of(3), seg_of(4'h1), DIGIT_CYC);
        drive(an_of(2), seg_of(4'hA), DIGIT_CYC);
        drive(an_of(1), 7'b1111111, DIGIT_CYC);
        drive_last(an_of(0), seg_of(4'hF), 16'h1A0F, 1'b1);

        drive(4'b0011, seg_of(4'h5), DIGIT_CYC);
        sweep(16'h1A2F, 1'b1);
        sweep(16'h1A2F, 1'b0);

        // Partial frame abandoned by timeout; later digits must not complete with it.
        drive(an_of(3), seg_of(4'h1), DIGIT_CYC);
        drive(an_of(2), seg_of(4'h2), DIGIT_CYC);
        check_eq("stale_before_tmo", O_stale, 0);
        drive(4'b1111, 7'b1111111, TIMEOUT + 50);
        check_eq("stale_after_tmo", O_stale, 1);
        check_eq("data_held_tmo", O_data, 16'h1A2F);
        drive(an_of(1), seg_of(4'hE), DIGIT_CYC);
        drive(an_of(0), seg_of(4'hF), DIGIT_CYC);
        drive(an_of(3), seg_of(4'hB), DIGIT_CYC);
        drive_last(an_of(2), seg_of(4'hE), 16'hBEEF, 1'b0);

        drive(an_of(3), seg_of(4'h5), DIGIT_CYC);
        drive(an_of(2), seg_of(4'h6), DIGIT_CYC);
        drive(an_of(1), seg_of(4'h7), DIGIT_CYC);
        smg_4_in = 4'b1111;
        smg_7_in = 7'b1111111;
        rst_n    = 1'b0;
        #1;
        check_eq("midrst_data", O_data, 0);
        check_eq("midrst_valid", O_valid, 0);
        check_eq("midrst_err", O_err, 0);
        check_eq("midrst_stale", O_stale, 1);
        tick(3);
        rst_n = 1'b1;
        tick(10);
        check_eq("postrst_stale", O_stale, 1);
        sweep(16'h5678, 1'b0);

        tick(20);
        check_eq("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
